// File: rtl/rx_ordering_arbiter_if.sv
// Head/descriptor bundle between the RX class buffers, the ordering arbiter and the dispatcher.
// bypass_total/drain_total exist only when RX_ORDERING_STATS_EN is defined.
interface rx_ordering_arbiter_if #(
    parameter int ID_W  = 16,
    parameter int SEQ_W = 8
);
    logic             p_valid, np_valid, cpl_valid;
    logic             p_ro, np_ro, cpl_ro;
    logic             p_ido, np_ido, cpl_ido;
    logic [ID_W-1:0]  p_id, np_id, cpl_id;
    logic [SEQ_W-1:0] p_seq, np_seq, cpl_seq;
    logic             p_sink_rdy, np_sink_rdy, cpl_sink_rdy;
    logic             p_pop, np_pop, cpl_pop;
    logic             out_valid;
    logic [1:0]       out_class;
    logic [SEQ_W-1:0] out_seq;
    logic             out_ready;
    logic             starve_drain;
`ifdef RX_ORDERING_STATS_EN
    logic [15:0]      bypass_total;
    logic [15:0]      drain_total;
`endif

    modport master (
        output p_valid, np_valid, cpl_valid, p_ro, np_ro, cpl_ro,
        output p_ido, np_ido, cpl_ido, p_id, np_id, cpl_id,
        output p_seq, np_seq, cpl_seq, p_sink_rdy, np_sink_rdy, cpl_sink_rdy,
        output out_ready,
        input  p_pop, np_pop, cpl_pop, out_valid, out_class, out_seq, starve_drain
`ifdef RX_ORDERING_STATS_EN
        , input bypass_total, drain_total
`endif
    );

    modport slave (
        input  p_valid, np_valid, cpl_valid, p_ro, np_ro, cpl_ro,
        input  p_ido, np_ido, cpl_ido, p_id, np_id, cpl_id,
        input  p_seq, np_seq, cpl_seq, p_sink_rdy, np_sink_rdy, cpl_sink_rdy,
        input  out_ready,
        output p_pop, np_pop, cpl_pop, out_valid, out_class, out_seq, starve_drain
`ifdef RX_ORDERING_STATS_EN
        , output bypass_total, drain_total
`endif
    );
endinterface

// File: rtl/rx_ordering_arbiter.sv
// RX ordering arbiter: grants one P/NP/CPL head per cycle under PCIe pass rules; stats via RX_ORDERING_STATS_EN.
// Latency: pop pulses in the grant cycle, descriptor valid on the following cycle.
// Backpressure: descriptor held while out_valid & !out_ready; no grant until the stage frees.
module rx_ordering_arbiter #(
    parameter int ID_W       = 16,
    parameter int SEQ_W      = 8,
    parameter int MAX_BYPASS = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    rx_ordering_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BYPASS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYPASS);
    localparam int P   = 0;
    localparam int NP  = 1;
    localparam int CPL = 2;

    typedef enum logic {NORMAL, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [SEQ_W-1:0] tgt_seq_q, tgt_seq_d;
    logic             out_vld_q, out_vld_d;
    logic [1:0]       out_cls_q, out_cls_d;
    logic [SEQ_W-1:0] out_seq_q, out_seq_d;

    logic [2:0]       vld, rdy, ro, ido;
    logic [ID_W-1:0]  id  [3];
    logic [SEQ_W-1:0] seq [3];
    logic [2:0]       oldest, elig, sel, pop_v;
    logic [1:0]       old_idx, sel_cls;
    logic [SEQ_W-1:0] old_seq, sel_seq;
    logic             free, grant, sel_is_oldest, tgt_present;

    assign vld = {bus.cpl_valid, bus.np_valid, bus.p_valid};
    assign rdy = {bus.cpl_sink_rdy, bus.np_sink_rdy, bus.p_sink_rdy};
    assign ro  = {bus.cpl_ro, bus.np_ro, bus.p_ro};
    assign ido = {bus.cpl_ido, bus.np_ido, bus.p_ido};
    assign id[P]    = bus.p_id;
    assign id[NP]   = bus.np_id;
    assign id[CPL]  = bus.cpl_id;
    assign seq[P]   = bus.p_seq;
    assign seq[NP]  = bus.np_seq;
    assign seq[CPL] = bus.cpl_seq;

    // Wrapping age compare: a is older than b when (a - b) lands in the upper half.
    function automatic logic older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
        logic [SEQ_W-1:0] diff;
        diff = a - b;
        return diff[SEQ_W-1];
    endfunction

    always_comb begin
        oldest = vld;
        elig   = vld & rdy;
        for (int x = 0; x < 3; x++) begin
            for (int y = 0; y < 3; y++) begin
                if (x != y && vld[y]) begin
                    if (!older(seq[x], seq[y])) oldest[x] = 1'b0;
                    // Only NP/CPL over an older P can be blocked.
                    if (older(seq[y], seq[x]) && y == P && x != P &&
                        !((ro[x] && ro[P]) || (ido[x] && ido[P] && (id[x] != id[P]))))
                        elig[x] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        old_idx     = 2'd0;
        old_seq     = '0;
        tgt_present = 1'b0;
        sel_cls     = 2'd0;
        sel_seq     = '0;
        sel         = '0;
        for (int i = 0; i < 3; i++) begin
            if (oldest[i]) begin
                old_idx = 2'(i);
                old_seq = seq[i];
            end
            if (tgt_q == 2'(i)) tgt_present = vld[i] && (seq[i] == tgt_seq_q);
        end

        if (state_q == DRAIN) begin
            if (tgt_present) sel = oldest & rdy;
        end else if (|(oldest & elig)) begin
            sel = oldest & elig;
        end else if (elig[P]) begin
            sel = 3'b001;
        end else if (elig[CPL]) begin
            sel = 3'b100;
        end else if (elig[NP]) begin
            sel = 3'b010;
        end

        free          = !out_vld_q || bus.out_ready;
        grant         = free && (|sel) && !arst;
        pop_v         = grant ? sel : 3'b000;
        sel_is_oldest = |(sel & oldest);
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) begin
                sel_cls = 2'(i + 1);
                sel_seq = seq[i];
            end
        end

        state_d   = state_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        tgt_seq_d = tgt_seq_q;
        out_vld_d = out_vld_q;
        out_cls_d = out_cls_q;
        out_seq_d = out_seq_q;

        if (free) begin
            out_vld_d = grant;
            out_cls_d = grant ? sel_cls : 2'd0;
            out_seq_d = grant ? sel_seq : '0;
        end

        case (state_q)
            NORMAL: begin
                if (grant) begin
                    if (sel_is_oldest) begin
                        cnt_d = '0;
                    end else begin
                        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                        // Remember which head we are draining for, so its vanishing can be detected.
                        if (cnt_d == CNT_MAX) begin
                            state_d   = DRAIN;
                            tgt_d     = old_idx;
                            tgt_seq_d = old_seq;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!tgt_present || grant) begin
                    state_d = NORMAL;
                    cnt_d   = '0;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= NORMAL;
            cnt_q     <= '0;
            tgt_q     <= 2'd0;
            tgt_seq_q <= '0;
            out_vld_q <= 1'b0;
            out_cls_q <= 2'd0;
            out_seq_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            tgt_seq_q <= tgt_seq_d;
            out_vld_q <= out_vld_d;
            out_cls_q <= out_cls_d;
            out_seq_q <= out_seq_d;
        end
    end

    assign bus.p_pop        = pop_v[P];
    assign bus.np_pop       = pop_v[NP];
    assign bus.cpl_pop      = pop_v[CPL];
    assign bus.out_valid    = out_vld_q;
    assign bus.out_class    = out_cls_q;
    assign bus.out_seq      = out_seq_q;
    assign bus.starve_drain = (state_q == DRAIN);

`ifdef RX_ORDERING_STATS_EN
    logic [15:0] byp_tot_q, byp_tot_d, drn_tot_q, drn_tot_d;

    always_comb begin
        byp_tot_d = byp_tot_q;
        drn_tot_d = drn_tot_q;
        if (grant && !sel_is_oldest && byp_tot_q != 16'hFFFF) byp_tot_d = byp_tot_q + 16'd1;
        if (state_q == NORMAL && state_d == DRAIN && drn_tot_q != 16'hFFFF) drn_tot_d = drn_tot_q + 16'd1;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            byp_tot_q <= '0;
            drn_tot_q <= '0;
        end else begin
            byp_tot_q <= byp_tot_d;
            drn_tot_q <= drn_tot_d;
        end
    end

    assign bus.bypass_total = byp_tot_q;
    assign bus.drain_total  = drn_tot_q;
`endif
endmodule

// File: tb/tb_rx_ordering_arbiter.sv
// Bench for rx_ordering_arbiter: directed ordering scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_rx_ordering_arbiter;
    localparam int ID_W  = 16;
    localparam int SEQ_W = 8;
    localparam int MAXB  = 4;
    localparam int MOD   = 1 << SEQ_W;

    typedef struct {
        int seq;
        bit ro;
        bit ido;
        int id;
    } tlp_t;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   next_seq;
    tlp_t qp[$], qn[$], qc[$];
    bit   rdy [3];

    // Reference model state
    bit m_drain, m_ovld;
    int m_cnt, m_tc, m_tseq, m_ocls, m_oseq, m_byp, m_drn;
    bit mv [3], mr [3], mro [3], mido [3];
    int ms [3], mid [3];

    always #5 clk = ~clk;

    rx_ordering_arbiter_if #(.ID_W(ID_W), .SEQ_W(SEQ_W)) bus ();
    rx_ordering_arbiter #(.ID_W(ID_W), .SEQ_W(SEQ_W), .MAX_BYPASS(MAXB)) dut (
        .clk (clk),
        .arst(arst),
        .bus (bus)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pops();
        return int'({bus.cpl_pop, bus.np_pop, bus.p_pop});
    endfunction

    function automatic bit is_older(int a, int b);
        return ((((a - b) % MOD) + MOD) % MOD) >= (MOD / 2);
    endfunction

    function automatic bit may_pass(int x, int y);
        if (y == 0 && x != 0)
            return (mro[x] && mro[0]) || (mido[x] && mido[0] && (mid[x] != mid[0]));
        return 1'b1;
    endfunction

    task automatic push(input int c, input int s, input bit ro, input bit ido, input int id);
        tlp_t t;
        t.seq = s; t.ro = ro; t.ido = ido; t.id = id;
        case (c)
            0:       qp.push_back(t);
            1:       qn.push_back(t);
            default: qc.push_back(t);
        endcase
    endtask

    task automatic popq(input int c);
        case (c)
            0:       void'(qp.pop_front());
            1:       void'(qn.pop_front());
            default: void'(qc.pop_front());
        endcase
    endtask

    function automatic bit head(input int c, output tlp_t t);
        t = '{seq: 0, ro: 1'b0, ido: 1'b0, id: 0};
        case (c)
            0:       if (qp.size() > 0) begin t = qp[0]; return 1'b1; end
            1:       if (qn.size() > 0) begin t = qn[0]; return 1'b1; end
            default: if (qc.size() > 0) begin t = qc[0]; return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    task automatic drive();
        tlp_t t;
        bus.p_valid   = head(0, t);
        bus.p_seq     = SEQ_W'(t.seq); bus.p_ro = t.ro; bus.p_ido = t.ido; bus.p_id = ID_W'(t.id);
        bus.np_valid  = head(1, t);
        bus.np_seq    = SEQ_W'(t.seq); bus.np_ro = t.ro; bus.np_ido = t.ido; bus.np_id = ID_W'(t.id);
        bus.cpl_valid = head(2, t);
        bus.cpl_seq   = SEQ_W'(t.seq); bus.cpl_ro = t.ro; bus.cpl_ido = t.ido; bus.cpl_id = ID_W'(t.id);
        bus.p_sink_rdy   = rdy[0];
        bus.np_sink_rdy  = rdy[1];
        bus.cpl_sink_rdy = rdy[2];
    endtask

    task automatic set_rdy(input bit p, input bit np, input bit cpl);
        rdy[0] = p; rdy[1] = np; rdy[2] = cpl;
        drive();
    endtask

    // One cycle: remember what popped, then let the buffers advance after the edge.
    task automatic tick();
        int pp;
        @(negedge clk);
        pp = pops();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) if (pp[c]) popq(c);
        drive();
    endtask

    task automatic do_reset();
        qp.delete(); qn.delete(); qc.delete();
        arst = 1'b1;
        drive();
        @(posedge clk);
        #1;
        cmp("rst_out_valid", int'(bus.out_valid), 0);
        cmp("rst_starve", int'(bus.starve_drain), 0);
        cmp("rst_pops", pops(), 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        drive();
    endtask

    // Reference model: judged from the ordering rules on the heads visible this cycle.
    always @(negedge clk) begin
        int  oi, pick;
        bit  leave, free, is_old;
        bit  el [3];
        if (arst) begin
            m_drain = 0; m_cnt = 0; m_tc = 0; m_tseq = 0;
            m_ovld = 0; m_ocls = 0; m_oseq = 0; m_byp = 0; m_drn = 0;
            cmp("reset_pops", pops(), 0);
            cmp("reset_out_valid", int'(bus.out_valid), 0);
            cmp("reset_starve", int'(bus.starve_drain), 0);
        end else begin
            mv[0] = bus.p_valid;   mr[0] = bus.p_sink_rdy;   ms[0] = int'(bus.p_seq);
            mro[0] = bus.p_ro;     mido[0] = bus.p_ido;      mid[0] = int'(bus.p_id);
            mv[1] = bus.np_valid;  mr[1] = bus.np_sink_rdy;  ms[1] = int'(bus.np_seq);
            mro[1] = bus.np_ro;    mido[1] = bus.np_ido;     mid[1] = int'(bus.np_id);
            mv[2] = bus.cpl_valid; mr[2] = bus.cpl_sink_rdy; ms[2] = int'(bus.cpl_seq);
            mro[2] = bus.cpl_ro;   mido[2] = bus.cpl_ido;    mid[2] = int'(bus.cpl_id);

            oi = -1;
            for (int i = 0; i < 3; i++) begin
                if (mv[i]) begin
                    is_old = 1'b1;
                    for (int j = 0; j < 3; j++)
                        if (j != i && mv[j] && !is_older(ms[i], ms[j])) is_old = 1'b0;
                    if (is_old) oi = i;
                end
            end

            pick = -1;
            leave = 1'b0;
            if (m_drain) begin
                if (!(mv[m_tc] && ms[m_tc] == m_tseq)) leave = 1'b1;
                else if (oi == m_tc && mr[m_tc]) pick = m_tc;
            end else begin
                for (int x = 0; x < 3; x++) begin
                    el[x] = mv[x] && mr[x];
                    for (int y = 0; y < 3; y++)
                        if (y != x && mv[y] && is_older(ms[y], ms[x]) && !may_pass(x, y)) el[x] = 1'b0;
                end
                if (oi >= 0 && el[oi]) pick = oi;
                if (pick < 0 && el[0]) pick = 0;
                if (pick < 0 && el[2]) pick = 2;
                if (pick < 0 && el[1]) pick = 1;
            end
            free = !m_ovld || bus.out_ready;
            if (!free) pick = -1;

            cmp("pops", pops(), (pick < 0) ? 0 : (1 << pick));
            cmp("out_valid", int'(bus.out_valid), int'(m_ovld));
            cmp("out_class", int'(bus.out_class), m_ocls);
            if (m_ovld) cmp("out_seq", int'(bus.out_seq), m_oseq);
            cmp("starve_drain", int'(bus.starve_drain), int'(m_drain));
`ifdef RX_ORDERING_STATS_EN
            cmp("bypass_total", int'(bus.bypass_total), m_byp);
            cmp("drain_total", int'(bus.drain_total), m_drn);
`endif

            if (free) begin
                m_ovld = (pick >= 0);
                m_ocls = 0;
                m_oseq = 0;
                if (pick >= 0) begin
                    m_ocls = pick + 1;
                    m_oseq = ms[pick];
                end
            end
            if (m_drain) begin
                if (leave || pick >= 0) begin
                    m_drain = 1'b0;
                    m_cnt   = 0;
                end
            end else if (pick >= 0) begin
                if (pick == oi) begin
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (m_byp < 65535) m_byp++;
                    if (m_cnt >= MAXB) begin
                        m_drain = 1'b1;
                        m_tc    = oi;
                        m_tseq  = ms[oi];
                        if (m_drn < 65535) m_drn++;
                    end
                end
            end
        end
    end

    initial begin
        tlp_t t;
        bit   ok;
        next_seq = 200;
        rdy[0] = 1; rdy[1] = 1; rdy[2] = 1;
        bus.out_ready = 1'b1;
        drive();

        // Older CPL goes first, then P
        do_reset();
        set_rdy(1, 1, 1);
        push(0, 5, 0, 0, 0); push(2, 3, 0, 0, 0); drive();
        #1 cmp("t1_cpl_pop", pops(), 3'b100);
        tick();
        #1 cmp("t1_class_cpl", int'(bus.out_class), 3);
        cmp("t1_seq_3", int'(bus.out_seq), 3);
        cmp("t1_p_pop", pops(), 3'b001);
        tick();
        #1 cmp("t1_class_p", int'(bus.out_class), 1);
        cmp("t1_seq_5", int'(bus.out_seq), 5);

        // NP may not pass a strict-ordered P
        do_reset();
        set_rdy(0, 1, 1);
        push(0, 2, 0, 0, 0); push(1, 7, 0, 0, 0); drive();
        #1 cmp("t2_blocked0", pops(), 0);
        tick();
        #1 cmp("t2_blocked1", pops(), 0);
        set_rdy(1, 1, 1);
        #1 cmp("t2_p_pop", pops(), 3'b001);
        tick();
        #1 cmp("t2_np_pop", pops(), 3'b010);

        // Relaxed ordering lets NP pass
        do_reset();
        set_rdy(0, 1, 1);
        push(0, 2, 1, 0, 0); push(1, 7, 1, 0, 0); drive();
        #1 cmp("t3_np_pop", pops(), 3'b010);
        tick();
        #1 cmp("t3_class_np", int'(bus.out_class), 2);
        cmp("t3_seq_7", int'(bus.out_seq), 7);

        // Starvation: four IDO bypasses, then drain for the blocked P
        do_reset();
        set_rdy(0, 1, 1);
        push(0, 10, 0, 1, 'h0100);
        for (int k = 0; k < 8; k++) push(2, 11 + k, 0, 1, 'h0200);
        drive();
        for (int k = 0; k < MAXB; k++) begin
            #1 cmp("t4_cpl_bypass", pops(), 3'b100);
            cmp("t4_not_drain", int'(bus.starve_drain), 0);
            tick();
        end
        #1 cmp("t4_drain", int'(bus.starve_drain), 1);
        cmp("t4_cpl_held", pops(), 0);
        tick();
        #1 cmp("t4_still_held", pops(), 0);
        set_rdy(1, 1, 1);
        #1 cmp("t4_p_pop", pops(), 3'b001);
        tick();
        #1 cmp("t4_drain_exit", int'(bus.starve_drain), 0);
        cmp("t4_cpl_resume", pops(), 3'b100);

        // Tag wrap: 250 is older than 2
        do_reset();
        set_rdy(1, 1, 1);
        push(1, 250, 0, 0, 0); push(0, 2, 0, 0, 0); drive();
        #1 cmp("t5_np_first", pops(), 3'b010);
        tick();
        #1 cmp("t5_seq_250", int'(bus.out_seq), 250);
        cmp("t5_p_next", pops(), 3'b001);

        // Backpressure hold, then reset discards the held descriptor
        do_reset();
        set_rdy(1, 1, 1);
        bus.out_ready = 1'b0;
        push(0, 1, 0, 0, 0); push(1, 2, 0, 0, 0); drive();
        #1 cmp("t6_p_pop", pops(), 3'b001);
        tick();
        #1 cmp("t6_held_vld", int'(bus.out_valid), 1);
        cmp("t6_no_pop1", pops(), 0);
        tick();
        #1 cmp("t6_held_seq", int'(bus.out_seq), 1);
        cmp("t6_no_pop2", pops(), 0);
        arst = 1'b1;
        #1 cmp("t6_rst_vld", int'(bus.out_valid), 0);
        cmp("t6_rst_pops", pops(), 0);
        @(posedge clk);
        #1 arst = 1'b0;
        bus.out_ready = 1'b1;
        drive();
        #1 cmp("t6_after_rst", pops(), 3'b010);
        tick();

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rdy[0] = ($urandom_range(99) < (((k / 400) % 2) ? 85 : 25));
            rdy[1] = ($urandom_range(99) < 75);
            rdy[2] = ($urandom_range(99) < 75);
            bus.out_ready = ($urandom_range(99) < 70);
            ok = (qp.size() + qn.size() + qc.size()) < 10;
            for (int c = 0; c < 3; c++)
                if (head(c, t) && ((((next_seq - t.seq) % MOD) + MOD) % MOD) >= 100) ok = 1'b0;
            if (ok && $urandom_range(99) < 45) begin
                push($urandom_range(2), next_seq, 1'($urandom_range(1)), 1'($urandom_range(1)),
                     $urandom_range(1));
                next_seq = (next_seq + 1) % MOD;
            end
            arst = (k % 997 == 500);
            drive();
            tick();
        end
        arst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
